ts4231_config_scheduler: RTL and testbench

- Sequences configuration and watch-entry of NUM_SENSORS TS4231 light sensors through one shared single-sensor configuration engine.
- Issues one request at a time, in index order, to that engine, and tracks per-sensor ready/failed status.
- Retries failed sensors up to a limit and periodically re-verifies all sensors.
- Sits between the system control/CSR logic and the TS4231 bus-driving engine.

---
 rtl/ts4231_pkg.sv | 38 +++
 rtl/ts4231_sched_timer.sv | 31 +++
 rtl/ts4231_config_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_ts4231_config_scheduler.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts4231_pkg.sv
// Shared types and constants for the TS4231 configuration scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ts4231_pkg;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SELECT    = 3'd1,
        ST_REQUEST   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_ABORT     = 3'd4,
        ST_HOLDOFF   = 3'd5
    } sched_state_t;

    // Sensor bus state codes as reported by the single-sensor engine.
    typedef enum logic [2:0] {
        BUS_SLEEP   = 3'd0,
        BUS_WATCH   = 3'd1,
        BUS_S3      = 3'd2,
        BUS_S0      = 3'd3,
        BUS_UNKNOWN = 3'd4
    } sensor_bus_state_t;

    // Default timing for a 50 MHz clock.
    localparam int DEF_CLK_HZ            = 50_000_000;
    localparam int DEF_OP_TIMEOUT_CYCLES = 5_000_000;   // 100 ms
    localparam int DEF_RECHECK_CYCLES    = 50_000_000;  // 1 s
    localparam int DEF_MAX_RETRIES       = 3;

    localparam int SENSOR_IDX_W = 8;
    localparam int RETRY_W      = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ts4231_sched_timer.sv
// Loadable down-counter shared by the operation timeout and the rescan holdoff.
// Latency: value loads on the clock after load; counts down one per cycle and holds at 0.
// Backpressure: none; load always wins over counting.
//
// Ports: clk, reset (async, active-high), load / load_value (restart count),
//        zero (count is 0).
module ts4231_sched_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ts4231_config_scheduler.sv
// Sequences configure/watch-entry of NUM_SENSORS TS4231 sensors through one shared engine.
// Latency: one request at a time; SELECT scans one index per cycle, results recorded the cycle after cfg_done.
// Backpressure: cfg_req held with stable cfg_sensor until cfg_ack; timeout forces a one-cycle cfg_abort.
//
// Ports: clk, reset (async, active-high), enable (run level), force_rescan (pulse),
//        cfg_req/cfg_sensor/cfg_ack/cfg_done/cfg_ok/cfg_abort (engine handshake),
//        sensor_ready/sensor_failed (per-sensor status), busy, pass_done (end-of-pass pulse).
module ts4231_config_scheduler
    import ts4231_pkg::*;
#(
    parameter int NUM_SENSORS       = 8,
    parameter int OP_TIMEOUT_CYCLES = DEF_OP_TIMEOUT_CYCLES,
    parameter int RECHECK_CYCLES    = DEF_RECHECK_CYCLES,
    parameter int MAX_RETRIES       = DEF_MAX_RETRIES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    force_rescan,
    output logic                    cfg_req,
    output logic [SENSOR_IDX_W-1:0] cfg_sensor,
    input  logic                    cfg_ack,
    input  logic                    cfg_done,
    input  logic                    cfg_ok,
    output logic                    cfg_abort,
    output logic [NUM_SENSORS-1:0]  sensor_ready,
    output logic [NUM_SENSORS-1:0]  sensor_failed,
    output logic                    busy,
    output logic                    pass_done
);

    localparam int TMR_W = $clog2(max_int(OP_TIMEOUT_CYCLES, RECHECK_CYCLES)) + 1;
    localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1;

    localparam logic [SENSOR_IDX_W-1:0] LAST_IDX  = SENSOR_IDX_W'(NUM_SENSORS - 1);
    localparam logic [TMR_W-1:0]        OP_LOAD   = TMR_W'(OP_TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0]        HOLD_LOAD = TMR_W'(RECHECK_CYCLES);
    localparam logic [RETRY_W-1:0]      RETRY_MAX = RETRY_W'(MAX_RETRIES);

    sched_state_t state, state_nxt;

    logic [SENSOR_IDX_W-1:0] ptr;
    // Set when the pointer steps past LAST_IDX; keeps the 8-bit pointer from
    // wrapping back to 0 when NUM_SENSORS is 256.
    logic                    ptr_end;
    logic                    rescan_pend;
    logic [RETRY_W-1:0]      retry [NUM_SENSORS];

    logic                    tmr_load;
    logic [TMR_W-1:0]        tmr_load_value;
    logic                    tmr_zero;

    logic                    ptr_clr, ptr_inc;
    logic                    rec_en, rec_ok;
    logic                    clr_flags;
    logic                    sensor_load;
    logic                    pend_set;
    logic                    rescan_now;
    logic [IDX_W-1:0]        ptr_idx, cur_idx;

    assign ptr_idx    = ptr[IDX_W-1:0];
    assign cur_idx    = cfg_sensor[IDX_W-1:0];
    assign rescan_now = force_rescan | rescan_pend;
    assign busy       = (state != ST_IDLE) && (state != ST_HOLDOFF);

    ts4231_sched_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .zero       (tmr_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        ptr_clr        = 1'b0;
        ptr_inc        = 1'b0;
        rec_en         = 1'b0;
        rec_ok         = 1'b0;
        clr_flags      = 1'b0;
        sensor_load    = 1'b0;
        pend_set       = 1'b0;
        cfg_req        = 1'b0;
        cfg_abort      = 1'b0;
        pass_done      = 1'b0;

        case (state)
            ST_IDLE: begin
                clr_flags = force_rescan;
                if (enable) begin
                    ptr_clr   = 1'b1;
                    state_nxt = ST_SELECT;
                end
            end

            ST_SELECT: begin
                if (force_rescan) begin
                    clr_flags = 1'b1;
                    ptr_clr   = 1'b1;
                end
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (force_rescan) begin
                    state_nxt = ST_SELECT;
                end else if (ptr_end) begin
                    pass_done      = 1'b1;
                    tmr_load       = 1'b1;
                    tmr_load_value = HOLD_LOAD;
                    state_nxt      = ST_HOLDOFF;
                end else if (sensor_failed[ptr_idx]) begin
                    ptr_inc = 1'b1;
                end else begin
                    sensor_load    = 1'b1;
                    tmr_load       = 1'b1;
                    tmr_load_value = OP_LOAD;
                    state_nxt      = ST_REQUEST;
                end
            end

            // A done seen while still requesting is a complete result; it
            // takes priority over both the timeout and the ack.
            ST_REQUEST: begin
                cfg_req  = 1'b1;
                pend_set = force_rescan;
                if (cfg_done) begin
                    rec_en = 1'b1;
                    rec_ok = cfg_ok;
                end else if (tmr_zero) begin
                    state_nxt = ST_ABORT;
                end else if (cfg_ack) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                pend_set = force_rescan;
                if (cfg_done) begin
                    rec_en = 1'b1;
                    rec_ok = cfg_ok;
                end else if (tmr_zero) begin
                    state_nxt = ST_ABORT;
                end
            end

            ST_ABORT: begin
                cfg_abort = 1'b1;
                pend_set  = force_rescan;
                rec_en    = 1'b1;
                rec_ok    = 1'b0;
            end

            ST_HOLDOFF: begin
                if (force_rescan) begin
                    clr_flags = 1'b1;
                    ptr_clr   = 1'b1;
                end
                if (!enable) begin
                    state_nxt = ST_IDLE;
                end else if (force_rescan || tmr_zero) begin
                    ptr_clr   = 1'b1;
                    state_nxt = ST_SELECT;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Common exit after a result is recorded: a pending rescan restarts
        // the pass from sensor 0, otherwise move on to the next index.
        if (rec_en) begin
            if (rescan_now) begin
                clr_flags = 1'b1;
                ptr_clr   = 1'b1;
            end else begin
                ptr_inc = 1'b1;
            end
            state_nxt = enable ? ST_SELECT : ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr         <= '0;
            ptr_end     <= 1'b0;
            rescan_pend <= 1'b0;
            cfg_sensor  <= '0;
        end else begin
            if (ptr_clr) begin
                ptr     <= '0;
                ptr_end <= 1'b0;
            end else if (ptr_inc) begin
                if (ptr == LAST_IDX) begin
                    ptr_end <= 1'b1;
                end else begin
                    ptr <= ptr + 1'b1;
                end
            end

            if (rec_en) begin
                rescan_pend <= 1'b0;
            end else if (pend_set) begin
                rescan_pend <= 1'b1;
            end

            if (sensor_load) begin
                cfg_sensor <= ptr;
            end
        end
    end

    // Per-sensor status. A rescan clear is applied after the result update so
    // the recorded ready bit survives while failed/retry are wiped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sensor_ready  <= '0;
            sensor_failed <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                retry[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (rec_en && (cur_idx == IDX_W'(i))) begin
                    if (rec_ok) begin
                        sensor_ready[i] <= 1'b1;
                        retry[i]        <= '0;
                    end else begin
                        sensor_ready[i] <= 1'b0;
                        if (retry[i] < RETRY_MAX) begin
                            retry[i] <= retry[i] + 4'd1;
                        end
                        if (retry[i] >= RETRY_MAX - 4'd1) begin
                            sensor_failed[i] <= 1'b1;
                        end
                    end
                end
                if (clr_flags) begin
                    sensor_failed[i] <= 1'b0;
                    retry[i]         <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ts4231_config_scheduler.sv
// Directed bench for ts4231_config_scheduler with a small behavioural engine.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_ts4231_config_scheduler;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         force_rescan;
    logic         cfg_req;
    logic [7:0]   cfg_sensor;
    logic         cfg_ack;
    logic         cfg_done;
    logic         cfg_ok;
    logic         cfg_abort;
    logic [N-1:0] sensor_ready;
    logic [N-1:0] sensor_failed;
    logic         busy;
    logic         pass_done;

    int errors = 0;
    int checks = 0;

    // Engine behaviour per sensor: done offset from request (0 = never answers).
    int eng_dly [N];
    bit eng_ok  [N];

    int req_log [$];
    int abort_cnt = 0;

    always #5 clk = ~clk;

    ts4231_config_scheduler #(
        .NUM_SENSORS       (N),
        .OP_TIMEOUT_CYCLES (100),
        .RECHECK_CYCLES    (50),
        .MAX_RETRIES       (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .force_rescan  (force_rescan),
        .cfg_req       (cfg_req),
        .cfg_sensor    (cfg_sensor),
        .cfg_ack       (cfg_ack),
        .cfg_done      (cfg_done),
        .cfg_ok        (cfg_ok),
        .cfg_abort     (cfg_abort),
        .sensor_ready  (sensor_ready),
        .sensor_failed (sensor_failed),
        .busy          (busy),
        .pass_done     (pass_done)
    );

    // Engine: offset 0 is the first negedge with cfg_req high; ack at offset 2,
    // done (one cycle) at offset eng_dly.
    initial begin
        int s;
        int d;
        cfg_ack  = 1'b0;
        cfg_done = 1'b0;
        cfg_ok   = 1'b0;
        forever begin
            @(negedge clk);
            if (cfg_req && !reset) begin
                s = int'(cfg_sensor);
                if (s >= N) s = 0;
                d = eng_dly[s];
                if (d == 0) begin
                    for (int k = 0; k < 400 && cfg_req; k++) @(negedge clk);
                end else begin
                    repeat (2) @(negedge clk);
                    cfg_ack = 1'b1;
                    @(negedge clk);
                    cfg_ack = 1'b0;
                    repeat (d - 3) @(negedge clk);
                    cfg_done = 1'b1;
                    cfg_ok   = eng_ok[s];
                    @(negedge clk);
                    cfg_done = 1'b0;
                    cfg_ok   = 1'b0;
                end
            end
        end
    end

    // Request / abort monitor.
    initial begin
        bit req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cfg_req && !req_prev) req_log.push_back(int'(cfg_sensor));
            req_prev = cfg_req;
            if (cfg_abort) abort_cnt++;
        end
    end

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; force_rescan = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (cfg_req !== 1'b0)        begin errors++; $display("FAIL reset_cfg_req: got %0b expected 0", cfg_req); end
        checks++; if (cfg_abort !== 1'b0)      begin errors++; $display("FAIL reset_cfg_abort: got %0b expected 0", cfg_abort); end
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (pass_done !== 1'b0)      begin errors++; $display("FAIL reset_pass_done: got %0b expected 0", pass_done); end
        checks++; if (cfg_sensor !== 8'd0)     begin errors++; $display("FAIL reset_cfg_sensor: got %0d expected 0", cfg_sensor); end
        checks++; if (sensor_ready !== 4'b0)   begin errors++; $display("FAIL reset_ready: got %b expected 0000", sensor_ready); end
        checks++; if (sensor_failed !== 4'b0)  begin errors++; $display("FAIL reset_failed: got %b expected 0000", sensor_failed); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL idle_busy: got %0b expected 0", busy); end
        checks++; if (req_log.size() != 0)     begin errors++; $display("FAIL idle_no_req: got %0d requests expected 0", req_log.size()); end
    endtask

    task automatic test_normal_pass();
        int n;
        int g;
        req_log.delete();
        enable = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!pass_done && n < 1000);
        checks++; if (pass_done !== 1'b1) begin errors++; $display("FAIL normal_pass_done: got %0b expected 1 (timeout)", pass_done); end
        checks++; if (req_log.size() != 4) begin errors++; $display("FAIL normal_req_count: got %0d expected 4", req_log.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= req_log.size() || req_log[i] != i) begin
                errors++;
                $display("FAIL normal_req_order[%0d]: got %0d expected %0d", i, (i < req_log.size()) ? req_log[i] : -1, i);
            end
        end
        checks++; if (sensor_ready !== 4'b1111) begin errors++; $display("FAIL normal_ready: got %b expected 1111", sensor_ready); end
        // pass_done in SELECT, 51 HOLDOFF cycles (50..0), SELECT, then REQUEST.
        g = 0;
        while (!cfg_req && g < 200) begin
            @(negedge clk);
            g++;
            if (g == 5) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL holdoff_busy: got %0b expected 0", busy); end
            end
        end
        checks++; if (g != 53) begin errors++; $display("FAIL holdoff_gap: got %0d cycles expected 53", g); end
        checks++; if (cfg_sensor !== 8'd0) begin errors++; $display("FAIL rescan_first_sensor: got %0d expected 0", cfg_sensor); end
    endtask

    task automatic test_timeout();
        int n;
        int c;
        int exp3 [3];
        exp3 = '{0, 1, 3};
        eng_dly[2] = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!(cfg_req && cfg_sensor == 8'd2) && n < 300);
        checks++; if (!(cfg_req && cfg_sensor == 8'd2)) begin errors++; $display("FAIL timeout_req2: got sensor %0d req %0b expected sensor 2 req 1", cfg_sensor, cfg_req); end
        // Timer holds 100 on the first request cycle and reaches 0 100 cycles
        // later; ABORT is the following cycle.
        c = 0;
        while (!cfg_abort && c < 300) begin @(negedge clk); c++; end
        checks++; if (c != 101) begin errors++; $display("FAIL timeout_abort_delay: got %0d cycles expected 101", c); end
        checks++; if (cfg_req !== 1'b0) begin errors++; $display("FAIL timeout_req_dropped: got %0b expected 0", cfg_req); end
        @(negedge clk);
        checks++; if (cfg_abort !== 1'b0) begin errors++; $display("FAIL timeout_abort_pulse: got %0b expected 0", cfg_abort); end
        n = 0;
        do begin @(negedge clk); n++; end while (!pass_done && n < 600);
        checks++; if (sensor_failed !== 4'b0000) begin errors++; $display("FAIL timeout_failed_pass1: got %b expected 0000", sensor_failed); end
        checks++; if (sensor_ready !== 4'b1011)  begin errors++; $display("FAIL timeout_ready_pass1: got %b expected 1011", sensor_ready); end
        n = 0;
        do begin @(negedge clk); n++; end while (!pass_done && n < 600);
        checks++; if (sensor_failed !== 4'b0100) begin errors++; $display("FAIL timeout_failed_pass2: got %b expected 0100", sensor_failed); end
        checks++; if (sensor_ready !== 4'b1011)  begin errors++; $display("FAIL timeout_ready_pass2: got %b expected 1011", sensor_ready); end
        req_log.delete();
        n = 0;
        do begin @(negedge clk); n++; end while (!pass_done && n < 600);
        checks++; if (req_log.size() != 3) begin errors++; $display("FAIL skip_req_count: got %0d expected 3", req_log.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= req_log.size() || req_log[i] != exp3[i]) begin
                errors++;
                $display("FAIL skip_req_order[%0d]: got %0d expected %0d", i, (i < req_log.size()) ? req_log[i] : -1, exp3[i]);
            end
        end
    endtask

    task automatic test_expiry_tie();
        int n;
        int a0;
        eng_dly[1] = 100;
        eng_ok[1]  = 1'b0;
        a0 = abort_cnt;
        n = 0;
        do begin @(negedge clk); n++; end while (!pass_done && n < 800);
        checks++; if (pass_done !== 1'b1)        begin errors++; $display("FAIL tie_pass_done: got %0b expected 1 (timeout)", pass_done); end
        checks++; if (abort_cnt != a0)           begin errors++; $display("FAIL tie_no_abort: got %0d aborts expected %0d", abort_cnt, a0); end
        checks++; if (sensor_ready !== 4'b1001)  begin errors++; $display("FAIL tie_ready: got %b expected 1001", sensor_ready); end
        checks++; if (sensor_failed !== 4'b0100) begin errors++; $display("FAIL tie_failed: got %b expected 0100", sensor_failed); end
    endtask

    task automatic test_force_rescan();
        int n;
        eng_dly[1] = 30;
        eng_ok[1]  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(cfg_req && cfg_sensor == 8'd1) && n < 300);
        checks++; if (!(cfg_req && cfg_sensor == 8'd1)) begin errors++; $display("FAIL force_req1: got sensor %0d req %0b expected sensor 1 req 1", cfg_sensor, cfg_req); end
        repeat (5) @(negedge clk);
        force_rescan = 1'b1;
        @(negedge clk);
        force_rescan = 1'b0;
        req_log.delete();
        eng_dly[2] = 10;
        n = 0;
        do begin @(negedge clk); n++; end while (req_log.size() == 0 && n < 200);
        checks++; if (req_log.size() == 0 || req_log[0] != 0) begin errors++; $display("FAIL force_next_sensor: got %0d expected 0", (req_log.size() > 0) ? req_log[0] : -1); end
        checks++; if (sensor_failed !== 4'b0000) begin errors++; $display("FAIL force_failed_clear: got %b expected 0000", sensor_failed); end
        checks++; if (sensor_ready !== 4'b1011)  begin errors++; $display("FAIL force_ready_kept: got %b expected 1011", sensor_ready); end
        n = 0;
        do begin @(negedge clk); n++; end while (!pass_done && n < 600);
        checks++; if (sensor_ready !== 4'b1111)  begin errors++; $display("FAIL force_pass_ready: got %b expected 1111", sensor_ready); end
        checks++; if (req_log.size() != 4)       begin errors++; $display("FAIL force_pass_count: got %0d expected 4", req_log.size()); end
    endtask

    task automatic test_enable_drop();
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (!cfg_req && n < 200);
        checks++; if (cfg_req !== 1'b1) begin errors++; $display("FAIL drop_req_seen: got %0b expected 1", cfg_req); end
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL drop_busy_at_done: got %0b expected 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy_after_done: got %0b expected 0", busy); end
        req_log.delete();
        repeat (200) @(negedge clk);
        checks++; if (req_log.size() != 0)       begin errors++; $display("FAIL drop_no_req: got %0d requests expected 0", req_log.size()); end
        checks++; if (sensor_ready !== 4'b1111)  begin errors++; $display("FAIL drop_ready_kept: got %b expected 1111", sensor_ready); end
        checks++; if (busy !== 1'b0)             begin errors++; $display("FAIL drop_idle: got %0b expected 0", busy); end
    endtask

    task automatic test_reset_mid_op();
        int n;
        enable = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cfg_req && n < 50);
        checks++; if (cfg_req !== 1'b1) begin errors++; $display("FAIL rst_req_seen: got %0b expected 1", cfg_req); end
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0)            begin errors++; $display("FAIL rst_async_busy: got %0b expected 0", busy); end
        checks++; if (cfg_req !== 1'b0)         begin errors++; $display("FAIL rst_async_req: got %0b expected 0", cfg_req); end
        checks++; if (sensor_ready !== 4'b0)    begin errors++; $display("FAIL rst_async_ready: got %b expected 0000", sensor_ready); end
        checks++; if (cfg_sensor !== 8'd0)      begin errors++; $display("FAIL rst_async_sensor: got %0d expected 0", cfg_sensor); end
        repeat (20) @(negedge clk);
        req_log.delete();
        reset = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!cfg_req && n < 20);
        checks++; if (n != 2)              begin errors++; $display("FAIL rst_first_req_latency: got %0d cycles expected 2", n); end
        checks++; if (cfg_sensor !== 8'd0) begin errors++; $display("FAIL rst_first_sensor: got %0d expected 0", cfg_sensor); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            eng_dly[i] = 10;
            eng_ok[i]  = 1'b1;
        end
        reset        = 1'b1;
        enable       = 1'b0;
        force_rescan = 1'b0;
        test_reset();
        test_normal_pass();
        test_timeout();
        test_expiry_tie();
        test_force_rescan();
        test_enable_drop();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
